// File: rtl/npc_pkg.sv
// rtl/npc_pkg.sv - shared types and constants for the fetch PC unit
package npc_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_J    = 3'd3,
    BR_JAL  = 3'd4,
    BR_JR   = 3'd5,
    BR_JALR = 3'd6
  } br_type_t;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] PC_STEP_DEFAULT  = 32'd4;

endpackage

// File: rtl/npc_pc_unit_if.sv
// rtl/npc_pc_unit_if.sv - ID control inputs and fetch PC outputs of the PC unit
interface npc_pc_unit_if;

  logic        stall;
  logic        id_valid;
  logic [2:0]  br_type;
  logic        cmp_eq;
  logic [31:0] rs_val;
  logic [15:0] imm16;
  logic [25:0] instr_index;
  logic [31:0] pc_if;
  logic [31:0] pc_id;
  logic [31:0] link_addr;
  logic        redirect;
  logic        misalign;

  modport master (
    output stall, id_valid, br_type, cmp_eq, rs_val, imm16, instr_index,
    input  pc_if, pc_id, link_addr, redirect, misalign
  );

  modport slave (
    input  stall, id_valid, br_type, cmp_eq, rs_val, imm16, instr_index,
    output pc_if, pc_id, link_addr, redirect, misalign
  );

endinterface

// File: rtl/npc_target.sv
// rtl/npc_target.sv - combinational taken/target resolution for the instruction in ID
module npc_target
  import npc_pkg::*;
(
  input  logic        id_valid,
  input  logic [2:0]  br_type,
  input  logic        cmp_eq,
  input  logic [31:0] pc_id,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  input  logic [31:0] rs_val,
  output logic        taken,
  output logic [31:0] target
);

  logic [31:0] br_target;

  assign br_target = pc_id + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};

  // Undefined encodings and bubbles fall through as not-taken.
  always_comb begin
    taken  = 1'b0;
    target = br_target;
    if (id_valid) begin
      case (br_type)
        BR_BEQ:  taken = cmp_eq;
        BR_BNE:  taken = !cmp_eq;
        BR_J, BR_JAL: begin
          taken  = 1'b1;
          target = {pc_id[31:28], instr_index, 2'b00};
        end
        BR_JR, BR_JALR: begin
          taken  = 1'b1;
          target = rs_val;
        end
        default: taken = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/npc_pc_unit.sv
// rtl/npc_pc_unit.sv - fetch PC owner with delay-slot redirect and stall hold
module npc_pc_unit
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
)
(
  input  logic          clk,
  input  logic          reset,
  npc_pc_unit_if.slave  bus
);

  state_t      state, state_nxt;
  logic [31:0] pc_if_q, pc_id_q, pc_if_nxt, target;
  logic        misalign_q, taken, advance, redirect;

  npc_target u_target (
    .id_valid    (bus.id_valid),
    .br_type     (bus.br_type),
    .cmp_eq      (bus.cmp_eq),
    .pc_id       (pc_id_q),
    .imm16       (bus.imm16),
    .instr_index (bus.instr_index),
    .rs_val      (bus.rs_val),
    .taken       (taken),
    .target      (target)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= BOOT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:      state_nxt = RUN;
      RUN, HOLD: state_nxt = bus.stall ? HOLD : RUN;
      default:   state_nxt = BOOT;
    endcase
  end

  // HOLD only differs from RUN in that it is observable; the decision on
  // release uses that cycle's (now fully forwarded) ID inputs.
  always_comb begin
    advance  = 1'b0;
    redirect = 1'b0;
    case (state)
      BOOT: advance = 1'b1;
      RUN, HOLD: begin
        advance  = !bus.stall;
        redirect = !bus.stall && taken;
      end
      default: ;
    endcase
  end

  assign pc_if_nxt = redirect ? target : pc_if_q + PC_STEP;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_if_q    <= RESET_PC;
      pc_id_q    <= RESET_PC;
      misalign_q <= 1'b0;
    end else if (advance) begin
      pc_id_q <= pc_if_q;
      pc_if_q <= pc_if_nxt;
      if (redirect && (target[1:0] != 2'b00)) misalign_q <= 1'b1;
    end
  end

  assign bus.pc_if     = pc_if_q;
  assign bus.pc_id     = pc_id_q;
  assign bus.link_addr = pc_id_q + 32'd8;
  assign bus.redirect  = redirect;
  assign bus.misalign  = misalign_q;

endmodule

// File: tb/tb_npc_pc_unit.sv
// tb/tb_npc_pc_unit.sv - directed vector bench for npc_pc_unit
module tb_npc_pc_unit;
  import npc_pkg::*;

  typedef struct {
    logic        rst;
    logic        chk;
    logic        stall;
    logic        vld;
    logic [2:0]  bt;
    logic        eq;
    logic [31:0] rs;
    logic [15:0] imm;
    logic [25:0] idx;
    logic [31:0] e_pcif;
    logic [31:0] e_pcid;
    logic        e_redir;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   nvec = 0;
  int   nmis = 0;
  vec_t tbl[$];

  npc_pc_unit_if bus ();

  npc_pc_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(logic rst, logic chk, logic stall, logic vld, logic [2:0] bt,
                             logic eq, logic [31:0] rs, logic [15:0] imm, logic [25:0] idx,
                             logic [31:0] pcif, logic [31:0] pcid, logic redir);
    vec_t r;
    r = '{rst, chk, stall, vld, bt, eq, rs, imm, idx, pcif, pcid, redir};
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic stall, logic vld, logic [2:0] bt, logic eq,
                       logic [31:0] rs, logic [15:0] imm, logic [25:0] idx);
    bus.stall = stall;
    bus.id_valid = vld;
    bus.br_type = bt;
    bus.cmp_eq = eq;
    bus.rs_val = rs;
    bus.imm16 = imm;
    bus.instr_index = idx;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(string tag, logic [31:0] pcif, logic [31:0] pcid, logic redir, logic mis);
    check({tag, " pc_if"}, bus.pc_if, pcif);
    check({tag, " pc_id"}, bus.pc_id, pcid);
    check({tag, " link_addr"}, bus.link_addr, pcid + 32'd8);
    check({tag, " redirect"}, {31'd0, bus.redirect}, {31'd0, redir});
    check({tag, " misalign"}, {31'd0, bus.misalign}, {31'd0, mis});
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, BR_NONE, 0, 0, 0, 0);

    tbl.push_back(v(0, 0, 0, 0, BR_NONE, 0, 0, 16'h0000, 26'h0, 32'h0, 32'h0, 0));
    tbl.push_back(v(0, 0, 0, 0, BR_NONE, 0, 0, 16'h0000, 26'h0, 32'h0, 32'h0, 0));
    // BOOT ignores a valid jump in ID
    tbl.push_back(v(1, 1, 0, 1, BR_J,    1, 0, 16'h0000, 26'h123, 32'h3000, 32'h3000, 0));
    tbl.push_back(v(1, 1, 0, 0, BR_NONE, 0, 0, 16'h0000, 26'h0, 32'h3004, 32'h3000, 0));
    tbl.push_back(v(1, 1, 0, 0, BR_NONE, 0, 0, 16'h0000, 26'h0, 32'h3008, 32'h3004, 0));
    tbl.push_back(v(1, 1, 0, 1, BR_BEQ,  1, 0, 16'h0004, 26'h0, 32'h300C, 32'h3008, 1));
    tbl.push_back(v(1, 1, 0, 0, BR_NONE, 0, 0, 16'h0000, 26'h0, 32'h301C, 32'h300C, 0));
    tbl.push_back(v(1, 1, 0, 1, BR_BEQ,  0, 0, 16'h0004, 26'h0, 32'h3020, 32'h301C, 0));
    tbl.push_back(v(1, 1, 0, 1, BR_JAL,  0, 0, 16'h0000, 26'h0000C40, 32'h3024, 32'h3020, 1));
    tbl.push_back(v(1, 1, 0, 0, BR_NONE, 0, 0, 16'h0000, 26'h0, 32'h3100, 32'h3024, 0));
    tbl.push_back(v(1, 1, 0, 0, BR_BEQ,  1, 0, 16'h0004, 26'h0, 32'h3104, 32'h3100, 0));
    tbl.push_back(v(1, 1, 0, 1, 3'd7,    1, 32'h8000, 16'h0004, 26'h1, 32'h3108, 32'h3104, 0));
    tbl.push_back(v(0, 0, 0, 0, BR_NONE, 0, 0, 16'h0000, 26'h0, 32'h0, 32'h0, 0));
    tbl.push_back(v(1, 1, 0, 0, BR_NONE, 0, 0, 16'h0000, 26'h0, 32'h3000, 32'h3000, 0));
    tbl.push_back(v(1, 1, 0, 0, BR_NONE, 0, 0, 16'h0000, 26'h0, 32'h3004, 32'h3000, 0));
    tbl.push_back(v(1, 1, 0, 0, BR_NONE, 0, 0, 16'h0000, 26'h0, 32'h3008, 32'h3004, 0));
    tbl.push_back(v(1, 1, 0, 0, BR_NONE, 0, 0, 16'h0000, 26'h0, 32'h300C, 32'h3008, 0));
    tbl.push_back(v(1, 1, 0, 0, BR_NONE, 0, 0, 16'h0000, 26'h0, 32'h3010, 32'h300C, 0));
    tbl.push_back(v(1, 1, 0, 1, BR_BNE,  1, 0, 16'h0040, 26'h0, 32'h3014, 32'h3010, 0));
    tbl.push_back(v(0, 0, 0, 0, BR_NONE, 0, 0, 16'h0000, 26'h0, 32'h0, 32'h0, 0));
    tbl.push_back(v(1, 1, 0, 0, BR_NONE, 0, 0, 16'h0000, 26'h0, 32'h3000, 32'h3000, 0));
    tbl.push_back(v(1, 1, 0, 0, BR_NONE, 0, 0, 16'h0000, 26'h0, 32'h3004, 32'h3000, 0));
    tbl.push_back(v(1, 1, 0, 0, BR_NONE, 0, 0, 16'h0000, 26'h0, 32'h3008, 32'h3004, 0));
    tbl.push_back(v(1, 1, 0, 0, BR_NONE, 0, 0, 16'h0000, 26'h0, 32'h300C, 32'h3008, 0));
    tbl.push_back(v(1, 1, 0, 0, BR_NONE, 0, 0, 16'h0000, 26'h0, 32'h3010, 32'h300C, 0));
    // backward branch: 3010 + 4 - 16 = 3004
    tbl.push_back(v(1, 1, 0, 1, BR_BEQ,  1, 0, 16'hFFFC, 26'h0, 32'h3014, 32'h3010, 1));
    tbl.push_back(v(1, 1, 0, 0, BR_NONE, 0, 0, 16'h0000, 26'h0, 32'h3004, 32'h3014, 0));
    tbl.push_back(v(1, 1, 0, 1, BR_BNE,  0, 0, 16'h0010, 26'h0, 32'h3008, 32'h3004, 1));
    tbl.push_back(v(1, 1, 0, 0, BR_NONE, 0, 0, 16'h0000, 26'h0, 32'h3048, 32'h3008, 0));

    foreach (tbl[i]) begin
      reset = tbl[i].rst;
      drive(tbl[i].stall, tbl[i].vld, tbl[i].bt, tbl[i].eq, tbl[i].rs, tbl[i].imm, tbl[i].idx);
      #4;
      if (tbl[i].chk) check_regs($sformatf("r%0d", i), tbl[i].e_pcif, tbl[i].e_pcid, tbl[i].e_redir, 1'b0);
      tick();
    end

    // JR held off by a three-cycle stall with untrusted operands
    drive(1, 1, BR_JR, 0, 32'h0000_4000, 0, 0);
    #4 check_regs("stall0", 32'h304C, 32'h3048, 0, 0);
    tick();
    for (int k = 1; k < 3; k++) begin
      drive(1, 1, BR_JR, 1'($urandom), $urandom, 16'($urandom), 26'($urandom));
      #4 check_regs($sformatf("stall%0d", k), 32'h304C, 32'h3048, 0, 0);
      tick();
    end
    drive(0, 1, BR_JR, 0, 32'h0000_4000, 0, 0);
    #4 check_regs("release", 32'h304C, 32'h3048, 1, 0);
    tick();
    drive(0, 1, BR_JR, 0, 32'h0000_3002, 0, 0);
    #4 check_regs("jr_misal", 32'h4000, 32'h304C, 1, 0);
    tick();
    drive(0, 0, BR_NONE, 0, 0, 0, 0);
    #4 check_regs("misal_set", 32'h3002, 32'h4000, 0, 1);
    tick();
    drive(0, 1, BR_JALR, 0, 32'h0000_5000, 0, 0);
    #4 check_regs("jalr", 32'h3006, 32'h3002, 1, 1);
    tick();

    // reset while HOLD has a pending taken branch
    drive(1, 1, BR_BEQ, 1, 0, 16'h0004, 0);
    #4 check_regs("hold_in", 32'h5000, 32'h3006, 0, 1);
    tick();
    reset = 1'b0;
    drive(0, 1, BR_BEQ, 1, 0, 16'h0004, 0);
    tick();
    reset = 1'b1;
    #4 check_regs("rst_hold", 32'h3000, 32'h3000, 0, 0);
    tick();
    #4 check_regs("boot_seq", 32'h3004, 32'h3000, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
